arb_req_l2: RTL
===============

ARB_REQ_L2 -- requirements
Module: arb_req_l2

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of requesters; power of two, 2..16.
REQ-002 SHALL have parameters ADDR_WIDTH 32, DATA_WIDTH 64, ID_WIDTH 16, BE_WIDTH DATA_WIDTH/8, TAG_WIDTH DATA_WIDTH/8, field widths.
REQ-003 SHALL have derived constant LOG_CH = $clog2(N_CH), pointer width.
REQ-004 Ports, in order:
- clk  in  1  clock; one clock domain, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_req_i  in  N_CH  per-channel request.
- data_add_i  in  N_CH x ADDR_WIDTH  address.
- data_wen_i  in  N_CH  write-enable, active-low.
- data_wdata_i  in  N_CH x DATA_WIDTH  write data.
- data_wtag_i  in  N_CH x TAG_WIDTH  write tag.
- data_be_i  in  N_CH x BE_WIDTH  byte enables.
- data_ID_i  in  N_CH x ID_WIDTH  requester ID.
- data_gnt_o  out  N_CH  per-channel grant.
- data_req_o, data_add_o, data_wen_o, data_wdata_o, data_wtag_o, data_be_o, data_ID_o  out  (widths as above)  arbitrated request to L2 bank.
- data_gnt_i  in  1  bank grant.
- rr_ptr_o  out  LOG_CH  current round-robin pointer, debug.

Function
REQ-005 data_req_o SHALL be the OR of data_req_i, combinational, zero latency.
REQ-006 Winner SHALL be the first channel with data_req_i set, scanning rr_ptr, rr_ptr+1, ... modulo N_CH.
REQ-007 All data_*_o payload fields SHALL be driven from the winner channel, combinationally in the same cycle.
REQ-008 With no request, payload outputs SHALL select channel rr_ptr; data_req_o and all data_gnt_o SHALL be 0.
REQ-009 data_gnt_o[w] SHALL equal data_gnt_i AND (w is the winner); at most one bit set per cycle.
REQ-010 A grant is a cycle with data_req_o=1 and data_gnt_i=1; on it, rr_ptr SHALL load (winner+1) mod N_CH at the next edge.
REQ-011 Without a grant, rr_ptr SHALL hold.
REQ-012 Wrap-around: winner N_CH-1 granted -> rr_ptr=0.
REQ-013 data_gnt_i=1 with no requests SHALL leave all state unchanged.
REQ-014 Fairness: with all channels requesting and data_gnt_i=1 every cycle, each channel SHALL be granted exactly once in every N_CH consecutive cycles.
REQ-015 Requesters SHALL hold req and payload stable until granted; a withdrawn request is not an error and simply leaves arbitration.

Reset
REQ-016 In a cycle with rst=1, state SHALL clear at the edge: rr_ptr=0, lock_vld=0, lock_ch=0.
REQ-017 rst SHALL take priority over a simultaneous grant; no pointer update occurs in that cycle.
REQ-018 Combinational outputs follow inputs during reset; rr_ptr_o reads 0 from the first edge with rst=1.

Configuration
REQ-019 Macro ARB_REQ_L2_LOCK_EN SHALL enable selection lock; registers lock_vld (1 bit) and lock_ch (LOG_CH).
REQ-020 With the macro, a cycle with data_req_o=1 and data_gnt_i=0 SHALL set lock_vld=1 and lock_ch=winner.
REQ-021 While lock_vld=1 and data_req_i[lock_ch]=1, winner SHALL be lock_ch regardless of rr_ptr or other requests.
REQ-022 lock_vld SHALL clear on grant of lock_ch, or when data_req_i[lock_ch] drops.
REQ-023 Without the macro, there SHALL be no lock registers, and the winner can change between ungranted cycles as requests arrive.

Structure
REQ-024 Package arb_l2_pkg SHALL hold the default width constants, and a function rr_next(ptr, n) returning (ptr+1) mod n.
REQ-025 Priority search SHALL be sub-module rr_prio_enc_l2 (inputs req vector, start pointer; outputs winner index and valid); mux and state stay in arb_req_l2.

Verification
REQ-026 N_CH=4, rst, req=4'b1111, gnt_i=1 for 8 cycles -> grants ch0,1,2,3,0,1,2,3; rr_ptr 1,2,3,0,...
REQ-027 rr_ptr=3, req=4'b1001, gnt_i=1 -> ch3 granted; payload = ch3 fields; next rr_ptr=0.
REQ-028 req=4'b0100, gnt_i=0 for 5 cycles -> gnt_o=0, rr_ptr holds; then gnt_i=1 -> gnt_o=4'b0100, rr_ptr=3.
REQ-029 LOCK_EN, rr_ptr=2: req=4'b0001 with gnt_i=0, then req=4'b0101 -> winner stays ch0 until granted; without LOCK_EN, winner switches to ch2.
REQ-030 Grant of ch1 in same cycle as rst=1 -> rr_ptr=0 next cycle, lock_vld=0.
REQ-031 req=0, gnt_i=1 -> data_req_o=0, gnt_o=0, rr_ptr unchanged.

Source files
------------

// File: rtl/arb_l2_pkg.sv
// Shared width defaults and pointer helper for the L2 request arbiter.
package arb_l2_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ID_WIDTH_DEF   = 16;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/rr_prio_enc_l2.sv
// Rotating priority encoder: first set bit of req scanning start, start+1, ... modulo N_CH.
// Purely combinational; with no request idx returns start and vld is low.
module rr_prio_enc_l2 #(
  parameter int N_CH   = 4,
  parameter int LOG_CH = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]   req,
  input  logic [LOG_CH-1:0] start,
  output logic [LOG_CH-1:0] idx,
  output logic              vld
);

  logic [LOG_CH-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    idx  = start;
    vld  = 1'b0;
    cand = start;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = start + LOG_CH'(i);
      if (req[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_req_l2.sv
// Round-robin arbiter of N_CH requesters onto one L2 bank port; request path is combinational.
// Define ARB_REQ_L2_LOCK_EN to hold the selection on an ungranted winner until it is granted or withdrawn.
module arb_req_l2
  import arb_l2_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = DATA_WIDTH / 8,
  parameter int LOG_CH     = $clog2(N_CH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CH-1:0]                      data_req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      data_add_i,
  input  logic [N_CH-1:0]                      data_wen_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [N_CH-1:0][TAG_WIDTH-1:0]       data_wtag_i,
  input  logic [N_CH-1:0][BE_WIDTH-1:0]        data_be_i,
  input  logic [N_CH-1:0][ID_WIDTH-1:0]        data_ID_i,
  output logic [N_CH-1:0]                      data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [TAG_WIDTH-1:0]                 data_wtag_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  input  logic                                 data_gnt_i,
  output logic [LOG_CH-1:0]                    rr_ptr_o
);

  logic [LOG_CH-1:0] rr_ptr;
  logic [LOG_CH-1:0] enc_idx;
  logic              enc_vld;
  logic [LOG_CH-1:0] winner;
  logic              grant;

  rr_prio_enc_l2 #(
    .N_CH   (N_CH),
    .LOG_CH (LOG_CH)
  ) u_prio (
    .req   (data_req_i),
    .start (rr_ptr),
    .idx   (enc_idx),
    .vld   (enc_vld)
  );

  assign data_req_o = |data_req_i;
  assign grant      = enc_vld & data_gnt_i;

`ifdef ARB_REQ_L2_LOCK_EN
  logic              lock_vld;
  logic [LOG_CH-1:0] lock_ch;

  assign winner = (lock_vld && data_req_i[lock_ch]) ? lock_ch : enc_idx;

  // An ungranted winner is pinned; a withdrawn lock owner falls back to normal scanning.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else if (grant) begin
      lock_vld <= 1'b0;
    end else if (enc_vld) begin
      lock_vld <= 1'b1;
      lock_ch  <= winner;
    end else begin
      lock_vld <= 1'b0;
    end
  end
`else
  assign winner = enc_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= LOG_CH'(rr_next(32'(winner), 32'(N_CH)));
    end
  end

  always_comb begin
    data_gnt_o = '0;
    if (grant) data_gnt_o[winner] = 1'b1;
  end

  assign data_add_o   = data_add_i[winner];
  assign data_wen_o   = data_wen_i[winner];
  assign data_wdata_o = data_wdata_i[winner];
  assign data_wtag_o  = data_wtag_i[winner];
  assign data_be_o    = data_be_i[winner];
  assign data_ID_o    = data_ID_i[winner];
  assign rr_ptr_o     = rr_ptr;

endmodule
